// File: rtl/qc_grader_pkg.sv
// qc_grader_pkg: shared types and helpers for the item-quality grader.
//   state_e  - controller states (IDLE/SAMPLE/GRADE/HOLD), 2-bit encoding
//   grade_e  - grade codes (NONE/LOW/MEDIUM/HIGH), 2-bit encoding
//   STAT_SEL_* - statistics select codes for stat_sel_i
//   popcount8 - number of set bits in an 8-bit vector
package qc_grader_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_GRADE  = 2'd2,
        S_HOLD   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GRADE_NONE   = 2'd0,
        GRADE_LOW    = 2'd1,
        GRADE_MEDIUM = 2'd2,
        GRADE_HIGH   = 2'd3
    } grade_e;

    localparam logic [1:0] STAT_SEL_TOTAL  = 2'd0;
    localparam logic [1:0] STAT_SEL_LOW    = 2'd1;
    localparam logic [1:0] STAT_SEL_MEDIUM = 2'd2;
    localparam logic [1:0] STAT_SEL_HIGH   = 2'd3;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/qc_sat_counter.sv
// qc_sat_counter: saturating event counter.
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear, has priority over inc
//   inc      - count one event (held at all-ones once reached)
//   cnt      - current count
module qc_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qc_grader.sv
// qc_grader: item-quality grading controller.
// Accepts an item on item_valid_i while item_ready_o is high, waits until the
// N_CRIT criterion inputs have been stable for SETTLE_CYC cycles, grades the
// item by pass count (all pass -> HIGH, >= MED_MIN -> MEDIUM, else LOW) and
// shows the grade on one-hot LEDs for HOLD_CYC cycles.
//
// Handshake: an item is accepted on any rising edge where item_valid_i and
// item_ready_o are both high; item_ready_o is high exactly while in IDLE, so
// a valid held high through HOLD is accepted on the first IDLE cycle.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   item_valid_i        - item present
//   item_ready_o        - controller idle, will accept (state decode)
//   crit_i              - per-criterion pass(1)/fail(0)
//   grade_o             - 0 none, 1 LOW, 2 MEDIUM, 3 HIGH (registered)
//   led_low_o/led_medium_o/led_high_o - one-hot grade LEDs (registered)
//   grade_valid_o       - one-cycle pulse in the first HOLD cycle
//   state_o             - current state encoding
//   stat_sel_i          - statistics select (0 total, 1 LOW, 2 MEDIUM, 3 HIGH)
//   clr_stats_i         - synchronous clear of all statistics counters
//   stat_cnt_o          - selected statistics counter (combinational mux)
//
// Build option: QC_GRADER_STATS_EN enables the statistics counters; without
// it stat_cnt_o is tied to zero and stat_sel_i/clr_stats_i are ignored.
module qc_grader
    import qc_grader_pkg::*;
#(
    parameter int N_CRIT     = 3,
    parameter int MED_MIN    = 2,
    parameter int SETTLE_CYC = 4,
    parameter int HOLD_CYC   = 8,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              item_valid_i,
    output logic              item_ready_o,
    input  logic [N_CRIT-1:0] crit_i,
    output logic [1:0]        grade_o,
    output logic              led_low_o,
    output logic              led_medium_o,
    output logic              led_high_o,
    output logic              grade_valid_o,
    output logic [1:0]        state_o,
    input  logic [1:0]        stat_sel_i,
    input  logic              clr_stats_i,
    output logic [CNT_W-1:0]  stat_cnt_o
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

    state_e            state_q, state_d;
    logic [N_CRIT-1:0] ref_q, ref_d;
    logic [7:0]        settle_q, settle_d;
    logic [7:0]        hold_q, hold_d;
    logic [1:0]        grade_q, grade_d;
    logic              gv_d;
    logic              stat_inc;
    logic [3:0]        passes;
    grade_e            grade_calc;

    // Grade is derived from the settled reference, not the live input.
    assign passes = popcount8(8'(ref_q));

    always_comb begin
        grade_calc = GRADE_LOW;
        if (passes == 4'(N_CRIT)) begin
            grade_calc = GRADE_HIGH;
        end else if (passes >= 4'(MED_MIN)) begin
            grade_calc = GRADE_MEDIUM;
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        grade_d  = grade_q;
        gv_d     = 1'b0;
        stat_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (item_valid_i) begin
                    ref_d    = crit_i;
                    settle_d = '0;
                    state_d  = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Any change restarts the stability window from the next cycle.
                if (crit_i != ref_q) begin
                    ref_d    = crit_i;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = S_GRADE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_GRADE: begin
                grade_d  = grade_calc;
                gv_d     = 1'b1;
                hold_d   = HOLD_LAST;
                stat_inc = 1'b1;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == 8'd0) begin
                    grade_d = GRADE_NONE;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ref_q         <= '0;
            settle_q      <= '0;
            hold_q        <= '0;
            grade_q       <= GRADE_NONE;
            grade_valid_o <= 1'b0;
            led_low_o     <= 1'b0;
            led_medium_o  <= 1'b0;
            led_high_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_q         <= ref_d;
            settle_q      <= settle_d;
            hold_q        <= hold_d;
            grade_q       <= grade_d;
            grade_valid_o <= gv_d;
            led_low_o     <= (grade_d == GRADE_LOW);
            led_medium_o  <= (grade_d == GRADE_MEDIUM);
            led_high_o    <= (grade_d == GRADE_HIGH);
        end
    end

    assign grade_o      = grade_q;
    assign state_o      = state_q;
    assign item_ready_o = (state_q == S_IDLE);

`ifdef QC_GRADER_STATS_EN
    logic [CNT_W-1:0] cnt_total, cnt_low, cnt_medium, cnt_high;

    qc_sat_counter #(.CNT_W(CNT_W)) u_cnt_total (
        .clk(clk), .rst(rst), .clr(clr_stats_i),
        .inc(stat_inc), .cnt(cnt_total)
    );
    qc_sat_counter #(.CNT_W(CNT_W)) u_cnt_low (
        .clk(clk), .rst(rst), .clr(clr_stats_i),
        .inc(stat_inc && (grade_calc == GRADE_LOW)), .cnt(cnt_low)
    );
    qc_sat_counter #(.CNT_W(CNT_W)) u_cnt_medium (
        .clk(clk), .rst(rst), .clr(clr_stats_i),
        .inc(stat_inc && (grade_calc == GRADE_MEDIUM)), .cnt(cnt_medium)
    );
    qc_sat_counter #(.CNT_W(CNT_W)) u_cnt_high (
        .clk(clk), .rst(rst), .clr(clr_stats_i),
        .inc(stat_inc && (grade_calc == GRADE_HIGH)), .cnt(cnt_high)
    );

    always_comb begin
        stat_cnt_o = cnt_total;
        case (stat_sel_i)
            STAT_SEL_LOW:    stat_cnt_o = cnt_low;
            STAT_SEL_MEDIUM: stat_cnt_o = cnt_medium;
            STAT_SEL_HIGH:   stat_cnt_o = cnt_high;
            default:         stat_cnt_o = cnt_total;
        endcase
    end
`else
    logic unused_stats;
    assign unused_stats = ^{stat_sel_i, clr_stats_i, stat_inc};
    assign stat_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_qc_grader.sv
// tb_qc_grader: directed bench for qc_grader with default parameters.
// The driver pushes {expected grade, expected valid cycle} per item into a
// queue; the monitor pops and compares whenever grade_valid_o is seen.
module tb_qc_grader;

    localparam int N_CRIT     = 3;
    localparam int MED_MIN    = 2;
    localparam int SETTLE_CYC = 4;
    localparam int HOLD_CYC   = 8;
    localparam int CNT_W      = 8;
    localparam int W          = 34;

    localparam logic [1:0] G_LOW  = 2'd1;
    localparam logic [1:0] G_MED  = 2'd2;
    localparam logic [1:0] G_HIGH = 2'd3;

    logic              clk;
    logic              rst;
    logic              item_valid_i;
    logic              item_ready_o;
    logic [N_CRIT-1:0] crit_i;
    logic [1:0]        grade_o;
    logic              led_low_o, led_medium_o, led_high_o;
    logic              grade_valid_o;
    logic [1:0]        state_o;
    logic [1:0]        stat_sel_i;
    logic              clr_stats_i;
    logic [CNT_W-1:0]  stat_cnt_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    qc_grader #(
        .N_CRIT(N_CRIT), .MED_MIN(MED_MIN), .SETTLE_CYC(SETTLE_CYC),
        .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .item_valid_i(item_valid_i), .item_ready_o(item_ready_o),
        .crit_i(crit_i), .grade_o(grade_o),
        .led_low_o(led_low_o), .led_medium_o(led_medium_o), .led_high_o(led_high_o),
        .grade_valid_o(grade_valid_o), .state_o(state_o),
        .stat_sel_i(stat_sel_i), .clr_stats_i(clr_stats_i), .stat_cnt_o(stat_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] leds_for(input logic [1:0] g);
        case (g)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int stat_exp(input int v);
`ifdef QC_GRADER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Presents an item at a negedge; returns at cycle T+1 (T = accept cycle).
    // If chg > 0, crit_i switches to c1 during cycle T+chg.
    task automatic send_item(input logic [2:0] c0, input logic [2:0] c1, input int chg,
                             input logic [1:0] g, input int lat, input bit keep,
                             output int t);
        int n;
        item_valid_i = 1'b1;
        crit_i = c0;
        n = 0;
        while (!item_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(item_ready_o), 32'd1);
        t = cyc;
        exp_q.push_back({g, 32'(t + lat)});
        @(negedge clk);
        if (!keep) item_valid_i = 1'b0;
        if (chg > 0) begin
            while (cyc < t + chg) @(negedge clk);
            crit_i = c1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!item_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(item_ready_o), 32'd1);
    endtask

    task automatic wait_hold();
        int n;
        n = 0;
        while (state_o != 2'd3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_timeout", 32'(state_o), 32'd3);
    endtask

    task automatic check_stat(input string name, input logic [1:0] sel, input int v);
        stat_sel_i = sel;
        #1;
        check(name, 32'(stat_cnt_o), 32'(stat_exp(v)));
    endtask

    task automatic pulse_clr();
        clr_stats_i = 1'b1;
        @(negedge clk);
        clr_stats_i = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            check("led_onehot", 32'({led_high_o, led_medium_o, led_low_o}), 32'(leds_for(grade_o)));
            if (grade_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grade_valid actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("grade", 32'(grade_o), 32'(e[33:32]));
                    check("grade_cycle", 32'(cyc), e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t, t2, n;
        rst = 1'b1;
        item_valid_i = 1'b0;
        crit_i = '0;
        stat_sel_i = 2'd0;
        clr_stats_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ready", 32'(item_ready_o), 32'd1);
        check("rst_grade", 32'(grade_o), 32'd0);
        check("rst_leds", 32'({led_high_o, led_medium_o, led_low_o}), 32'd0);
        check("rst_valid", 32'(grade_valid_o), 32'd0);
        check_stat("rst_total", 2'd0, 0);

        // HIGH item, full timing of the hold window
        send_item(3'b111, 3'b111, 0, G_HIGH, 6, 1'b0, t);
        while (cyc < t + 13) @(negedge clk);
        check("hold_last_led", 32'(led_high_o), 32'd1);
        check("hold_last_state", 32'(state_o), 32'd3);
        @(negedge clk);
        check("release_led", 32'(led_high_o), 32'd0);
        check("release_ready", 32'(item_ready_o), 32'd1);
        check("release_grade", 32'(grade_o), 32'd0);
        check_stat("first_total", 2'd0, 1);
        pulse_clr();
        check_stat("clr_total", 2'd0, 0);

        // MEDIUM, LOW, LOW
        send_item(3'b101, 3'b101, 0, G_MED, 6, 1'b0, t);
        wait_idle();
        send_item(3'b100, 3'b100, 0, G_LOW, 6, 1'b0, t);
        wait_idle();
        send_item(3'b000, 3'b000, 0, G_LOW, 6, 1'b0, t);
        wait_idle();
        check_stat("cnt_low", 2'd1, 2);
        check_stat("cnt_med", 2'd2, 1);
        check_stat("cnt_high", 2'd3, 0);
        check_stat("cnt_total", 2'd0, 3);

        // Criterion change in SAMPLE restarts the settle window
        send_item(3'b111, 3'b011, 3, G_MED, 9, 1'b0, t);
        wait_idle();
        check_stat("toggle_med", 2'd2, 2);

        // Valid held through HOLD: next accept on first IDLE cycle;
        // the new crit_i applied during HOLD does not alter the current grade.
        send_item(3'b111, 3'b111, 0, G_HIGH, 6, 1'b1, t);
        wait_hold();
        send_item(3'b100, 3'b100, 0, G_LOW, 6, 1'b0, t2);
        check("min_period", 32'(t2), 32'(t + SETTLE_CYC + HOLD_CYC + 2));
        wait_idle();
        check_stat("b2b_total", 2'd0, 6);
        check_stat("b2b_low", 2'd1, 3);

        // Reset during HOLD
        send_item(3'b111, 3'b111, 0, G_HIGH, 6, 1'b0, t);
        wait_hold();
        @(negedge clk);
        stat_sel_i = 2'd0;
        rst = 1'b1;
        #1;
        check("midrst_state", 32'(state_o), 32'd0);
        check("midrst_grade", 32'(grade_o), 32'd0);
        check("midrst_leds", 32'({led_high_o, led_medium_o, led_low_o}), 32'd0);
        check("midrst_valid", 32'(grade_valid_o), 32'd0);
        check("midrst_total", 32'(stat_cnt_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(item_ready_o), 32'd1);

        // Saturation: 260 HIGH items
        for (int i = 0; i < 260; i++) begin
            send_item(3'b111, 3'b111, 0, G_HIGH, 6, 1'b0, t);
            wait_idle();
        end
        check_stat("sat_high", 2'd3, 255);
        check_stat("sat_total", 2'd0, 255);
        check_stat("sat_low", 2'd1, 0);
        check_stat("sat_med", 2'd2, 0);

        // Clear coincident with GRADE wins over the increment
        send_item(3'b111, 3'b111, 0, G_HIGH, 6, 1'b0, t);
        while (cyc < t + SETTLE_CYC + 1) @(negedge clk);
        check("grade_state", 32'(state_o), 32'd2);
        pulse_clr();
        wait_idle();
        check_stat("clrwin_high", 2'd3, 0);
        check_stat("clrwin_total", 2'd0, 0);

        // Drain scoreboard
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qc_grader.md
# qc_grader

Parametrised item-quality grading controller: accepts an item through a valid/ready handshake, waits for its N pass/fail criterion inputs to settle, grades it LOW/MEDIUM/HIGH by pass count, and shows the grade on one-hot LEDs for a fixed hold time. It generalises the fixed 3-criterion weight/size/color grader to N criteria, adding settle filtering, an explicit handshake and optional per-grade statistics. It sits behind the Tiny Tapeout top wrapper, driven from `ui_in` and driving `uo_out`.

## Interface
- `N_CRIT`, 3, number of criterion inputs (1..8)
- `MED_MIN`, 2, minimum passes for MEDIUM (1..N_CRIT; MED_MIN = N_CRIT makes MEDIUM unreachable)
- `SETTLE_CYC`, 4, consecutive stable cycles required before grading (1..255)
- `HOLD_CYC`, 8, cycles the grade is displayed (1..255)
- `CNT_W`, 8, statistics counter width
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous active-high reset
- `item_valid_i` in 1, item present
- `item_ready_o` out 1, high only in IDLE
- `crit_i` in N_CRIT, per-criterion pass (1) / fail (0)
- `grade_o` out 2, 0 none, 1 LOW, 2 MEDIUM, 3 HIGH
- `led_low_o`, `led_medium_o`, `led_high_o` out 1 each, one-hot decode of `grade_o`
- `grade_valid_o` out 1, single-cycle pulse on new grade
- `state_o` out 2, current FSM state encoding
- `stat_sel_i` in 2, statistics select (1 LOW, 2 MEDIUM, 3 HIGH, 0 total)
- `clr_stats_i` in 1, synchronous clear of all counters
- `stat_cnt_o` out CNT_W, selected counter

## Operation
- States: IDLE=0, SAMPLE=1, GRADE=2, HOLD=3.
- IDLE: `item_ready_o`=1. `item_valid_i`=1 → accept, capture `crit_i` into reference register, clear settle counter, go SAMPLE.
- SAMPLE: each cycle compare `crit_i` to reference. Equal → counter+1; differ → reference ← `crit_i`, counter ← 0. Equal on the cycle counter reaches SETTLE_CYC−1 → GRADE.
- GRADE (1 cycle): passes = popcount(reference). passes = N_CRIT → HIGH; else passes ≥ MED_MIN → MEDIUM; else LOW. Register into `grade_o`, set `grade_valid_o`, load hold counter, go HOLD.
- HOLD: LEDs show grade for HOLD_CYC cycles; `crit_i` and `item_valid_i` ignored; on expiry `grade_o` ← 0, go IDLE.
- Statistics: on GRADE, increment total and selected grade counter; counters saturate at 2^CNT_W−1. `clr_stats_i` wins over a simultaneous increment. `stat_cnt_o` is combinational from `stat_sel_i`.
- Reset (any time, incl. mid-SAMPLE/HOLD): state IDLE, `grade_o`=0, all LEDs 0, `grade_valid_o`=0, `item_ready_o`=1 after release, counters 0, reference 0.

## Timing
- Accept edge ends cycle T. Undisturbed: SAMPLE T+1..T+SETTLE_CYC, GRADE T+SETTLE_CYC+1, `grade_o`/LEDs/`grade_valid_o` valid T+SETTLE_CYC+2, LEDs held through T+SETTLE_CYC+HOLD_CYC+1, IDLE (ready) next cycle.
- A criterion change in SAMPLE restarts the SETTLE_CYC window from the following cycle; no upper bound on SAMPLE duration.
- `grade_valid_o` high exactly one cycle (first HOLD cycle).
- `item_valid_i` held high across HOLD starts a new accept on the first IDLE cycle (minimum item period SETTLE_CYC+HOLD_CYC+2).
- All outputs registered except `item_ready_o` (state decode) and `stat_cnt_o` (mux).

## Configuration
- `QC_GRADER_STATS_EN` defined: counters, `clr_stats_i`, `stat_sel_i` functional as above.
- Undefined: no counters instantiated; `stat_cnt_o` tied 0; `stat_sel_i`, `clr_stats_i` unused. Grading behaviour identical.

## Structure
- Package `qc_grader_pkg`: state enum (IDLE/SAMPLE/GRADE/HOLD, 2 bits), grade enum (NONE/LOW/MEDIUM/HIGH, 2 bits), stat select constants.
- Sub-module `qc_sat_counter` (CNT_W, inc, clr, saturating), instantiated 4× under `QC_GRADER_STATS_EN`.

## Test plan
- Defaults, `crit_i`=3'b111 stable, one valid pulse → HIGH on `led_high_o` at T+6, `grade_valid_o` pulse at T+6, LEDs off and ready at T+14.
- `crit_i`=3'b101 → MEDIUM; 3'b100 → LOW; 3'b000 → LOW; counters LOW=2, MEDIUM=1, total=3.
- `crit_i` toggles 3'b111→3'b011 at T+3 then stable → grade MEDIUM, valid at T+9.
- Assert `rst` during HOLD → LEDs, `grade_o`, counters 0 immediately; `state_o`=0.
- 260 HIGH items with CNT_W=8 → HIGH and total saturate at 255; `clr_stats_i` coincident with GRADE → counter 0.
- Build without `QC_GRADER_STATS_EN` → same grades, `stat_cnt_o`=0 for every `stat_sel_i`.
